// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared types and encodings for the multicycle MIPS control unit
package mips_mc_pkg;

  // Control sequencer states
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_JR,
    S_TRAP
  } state_t;

  // Instruction classes produced by the opcode decoder
  typedef enum logic [3:0] {
    CLS_RTYPE,
    CLS_JR,
    CLS_LW,
    CLS_SW,
    CLS_ADDI,
    CLS_ANDI,
    CLS_BEQ,
    CLS_J,
    CLS_JAL,
    CLS_ILLEGAL
  } instr_cls_t;

  // Opcode and funct field values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // alu_op codes
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_AND   = 2'b11;

  // alu_src_b codes
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // pc_source codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  // reg_dst codes
  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  // mem_to_reg codes
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - IR fields, memory handshake and datapath controls
interface mips_multicycle_ctrl_if #(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 2
);
  logic [OP_W-1:0]    op_code;
  logic [FUNCT_W-1:0] funct;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic [1:0]         reg_dst;
  logic [1:0]         mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic [1:0]         pc_source;
  logic               illegal_op;
  logic               instr_done;

  // Control unit side
  modport slave (
    input  op_code, funct, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_done
  );

  // Datapath side
  modport master (
    output op_code, funct, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, instr_done
  );
endinterface

// File: rtl/mips_mc_op_decoder.sv
// rtl/mips_mc_op_decoder.sv - opcode/funct to instruction class (jal/jr gated by MIPS_MC_JAL_JR_EN)
module mips_mc_op_decoder
  import mips_mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
) (
  input  logic [OP_W-1:0]    i_op_code,
  input  logic [FUNCT_W-1:0] i_funct,
  output instr_cls_t         o_cls
);

  logic w_op_rtype;
  assign w_op_rtype = (i_op_code == OP_W'(OP_RTYPE));

`ifdef MIPS_MC_JAL_JR_EN
  logic w_fn_jr;
  assign w_fn_jr = (i_funct == FUNCT_W'(FN_JR));
`else
  // Without jr support funct plays no part in sequencing
  logic w_unused_funct;
  assign w_unused_funct = ^i_funct;
`endif

  // Classify the instruction; anything unrecognised is illegal
  always_comb begin
    o_cls = CLS_ILLEGAL;
    if (w_op_rtype) begin
`ifdef MIPS_MC_JAL_JR_EN
      o_cls = w_fn_jr ? CLS_JR : CLS_RTYPE;
`else
      o_cls = CLS_RTYPE;
`endif
    end
    else if (i_op_code == OP_W'(OP_LW))   o_cls = CLS_LW;
    else if (i_op_code == OP_W'(OP_SW))   o_cls = CLS_SW;
    else if (i_op_code == OP_W'(OP_ADDI)) o_cls = CLS_ADDI;
    else if (i_op_code == OP_W'(OP_ANDI)) o_cls = CLS_ANDI;
    else if (i_op_code == OP_W'(OP_BEQ))  o_cls = CLS_BEQ;
    else if (i_op_code == OP_W'(OP_J))    o_cls = CLS_J;
`ifdef MIPS_MC_JAL_JR_EN
    else if (i_op_code == OP_W'(OP_JAL))  o_cls = CLS_JAL;
`endif
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM (jal/jr enabled by MIPS_MC_JAL_JR_EN)
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  mips_multicycle_ctrl_if.slave bus
);

  state_t     r_state;
  state_t     w_next;
  instr_cls_t r_cls;
  instr_cls_t w_cls;

  logic       w_pc_write, w_pc_write_cond, w_iord, w_mem_read, w_mem_write;
  logic       w_ir_write, w_reg_write, w_alu_src_a, w_illegal_op, w_instr_done;
  logic [1:0] w_reg_dst, w_mem_to_reg, w_alu_src_b, w_alu_op, w_pc_source;

  mips_mc_op_decoder #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W)
  ) u_dec (
    .i_op_code (bus.op_code),
    .i_funct   (bus.funct),
    .o_cls     (w_cls)
  );

  // State register; the class is captured in DECODE so later states do not depend on the IR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cls   <= CLS_ILLEGAL;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cls <= w_cls;
    end
  end

  // Next state and Moore outputs; mem_ready only qualifies the three memory wait states
  always_comb begin
    w_next          = r_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_illegal_op    = 1'b0;
    w_instr_done    = 1'b0;
    w_reg_dst       = RDST_RT;
    w_mem_to_reg    = M2R_ALU;
    w_alu_src_b     = SRCB_B;
    w_alu_op        = ALU_ADD;
    w_pc_source     = PCSRC_ALU;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alu_src_b = SRCB_IMM_SH;
        case (w_cls)
          CLS_RTYPE:          w_next = S_EXEC_R;
          CLS_LW, CLS_SW:     w_next = S_MEM_ADDR;
          CLS_ADDI, CLS_ANDI: w_next = S_EXEC_I;
          CLS_BEQ:            w_next = S_BRANCH;
          CLS_J:              w_next = S_JUMP;
`ifdef MIPS_MC_JAL_JR_EN
          CLS_JAL:            w_next = S_JAL;
          CLS_JR:             w_next = S_JR;
`endif
          default:            w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = (r_cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (bus.mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = M2R_MDR;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (bus.mem_ready) begin
          w_instr_done = 1'b1;
          w_next       = S_FETCH;
        end
      end
      S_EXEC_R: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_B;
        w_alu_op    = ALU_FUNCT;
        w_next      = S_ALU_WB;
      end
      S_EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_alu_op    = (r_cls == CLS_ANDI) ? ALU_AND : ALU_ADD;
        w_next      = S_ALU_WB;
      end
      S_ALU_WB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = (r_cls == CLS_RTYPE) ? RDST_RD : RDST_RT;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = ALU_SUB;
        w_pc_write_cond = 1'b1;
        w_pc_source     = PCSRC_ALUOUT;
        w_instr_done    = 1'b1;
        w_next          = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write   = 1'b1;
        w_pc_source  = PCSRC_JUMP;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
`ifdef MIPS_MC_JAL_JR_EN
      S_JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value
        w_pc_write   = 1'b1;
        w_pc_source  = PCSRC_JUMP;
        w_reg_write  = 1'b1;
        w_reg_dst    = RDST_RA;
        w_mem_to_reg = M2R_PC;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      S_JR: begin
        w_pc_write   = 1'b1;
        w_pc_source  = PCSRC_REG;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
`endif
      S_TRAP: begin
        w_illegal_op = 1'b1;
        w_instr_done = 1'b1;
        w_next       = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // Reset blanks every control immediately, including the FETCH defaults
    if (!rst_n) begin
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_iord          = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_ir_write      = 1'b0;
      w_reg_write     = 1'b0;
      w_alu_src_a     = 1'b0;
      w_illegal_op    = 1'b0;
      w_instr_done    = 1'b0;
      w_reg_dst       = 2'b00;
      w_mem_to_reg    = 2'b00;
      w_alu_src_b     = 2'b00;
      w_alu_op        = 2'b00;
      w_pc_source     = 2'b00;
    end
  end

  assign bus.pc_write      = w_pc_write;
  assign bus.pc_write_cond = w_pc_write_cond;
  assign bus.iord          = w_iord;
  assign bus.mem_read      = w_mem_read;
  assign bus.mem_write     = w_mem_write;
  assign bus.ir_write      = w_ir_write;
  assign bus.reg_dst       = w_reg_dst;
  assign bus.mem_to_reg    = w_mem_to_reg;
  assign bus.reg_write     = w_reg_write;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.alu_op        = ALUOP_W'(w_alu_op);
  assign bus.pc_source     = w_pc_source;
  assign bus.illegal_op    = w_illegal_op;
  assign bus.instr_done    = w_instr_done;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mips_multicycle_ctrl_if #(.OP_W(6), .FUNCT_W(6), .ALUOP_W(2)) bus ();

  mips_multicycle_ctrl #(.OP_W(6), .FUNCT_W(6), .ALUOP_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       instr_done;
  } ctl_t;

  typedef struct {
    string      tag;
    logic       mr;
    logic [5:0] op;
    logic [5:0] fn;
    ctl_t       c;
  } step_t;

  typedef enum {K_R, K_JR, K_LW, K_SW, K_ADDI, K_ANDI, K_BEQ, K_J, K_JAL, K_TRAP} kind_t;

  step_t q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%05h expected=%05h", tag, got, exp);
    end
  endtask

  function automatic ctl_t sample();
    ctl_t s;
    s.pc_write      = bus.pc_write;
    s.pc_write_cond = bus.pc_write_cond;
    s.iord          = bus.iord;
    s.mem_read      = bus.mem_read;
    s.mem_write     = bus.mem_write;
    s.ir_write      = bus.ir_write;
    s.reg_dst       = bus.reg_dst;
    s.mem_to_reg    = bus.mem_to_reg;
    s.reg_write     = bus.reg_write;
    s.alu_src_a     = bus.alu_src_a;
    s.alu_src_b     = bus.alu_src_b;
    s.alu_op        = bus.alu_op;
    s.pc_source     = bus.pc_source;
    s.illegal_op    = bus.illegal_op;
    s.instr_done    = bus.instr_done;
    return s;
  endfunction

  function automatic kind_t kind(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
`ifdef MIPS_MC_JAL_JR_EN
        if (fn == 6'b001000) return K_JR;
`endif
        return K_R;
      end
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b001000: return K_ADDI;
      6'b001100: return K_ANDI;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
`ifdef MIPS_MC_JAL_JR_EN
      6'b000011: return K_JAL;
`endif
      default:   return K_TRAP;
    endcase
  endfunction

  // Cycle where op/funct and mem_ready must not matter: drive junk on them
  task automatic push_r(input string tag, input logic mr, input ctl_t c);
    step_t s;
    s.tag = tag; s.mr = mr; s.op = 6'($urandom); s.fn = 6'($urandom); s.c = c;
    q.push_back(s);
  endtask

  // Expected cycle-by-cycle control trace of one instruction
  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input int w0, input int w1);
    ctl_t  c;
    step_t s;
    kind_t k;
    for (int i = 0; i < w0; i++) begin
      c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
      push_r("fetch_wait", 1'b0, c);
    end
    c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = 1'b1; c.pc_write = 1'b1;
    push_r("fetch", 1'b1, c);
    c = '0; c.alu_src_b = 2'b11;
    s.tag = "decode"; s.mr = 1'($urandom); s.op = op; s.fn = fn; s.c = c;
    q.push_back(s);
    k = kind(op, fn);
    case (k)
      K_R, K_ADDI, K_ANDI: begin
        c = '0; c.alu_src_a = 1'b1;
        c.alu_src_b = (k == K_R) ? 2'b00 : 2'b10;
        c.alu_op    = (k == K_R) ? 2'b10 : (k == K_ANDI) ? 2'b11 : 2'b00;
        push_r("exec", 1'($urandom), c);
        c = '0; c.reg_write = 1'b1; c.instr_done = 1'b1;
        c.reg_dst = (k == K_R) ? 2'b01 : 2'b00;
        push_r("alu_wb", 1'($urandom), c);
      end
      K_LW, K_SW: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        push_r("mem_addr", 1'($urandom), c);
        c = '0; c.iord = 1'b1;
        if (k == K_LW) c.mem_read = 1'b1; else c.mem_write = 1'b1;
        for (int i = 0; i < w1; i++) push_r("mem_wait", 1'b0, c);
        if (k == K_SW) c.instr_done = 1'b1;
        push_r("mem_done", 1'b1, c);
        if (k == K_LW) begin
          c = '0; c.reg_write = 1'b1; c.mem_to_reg = 2'b01; c.instr_done = 1'b1;
          push_r("mem_wb", 1'($urandom), c);
        end
      end
      K_BEQ: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
        c.pc_source = 2'b01; c.instr_done = 1'b1;
        push_r("branch", 1'($urandom), c);
      end
      K_J, K_JAL: begin
        c = '0; c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1;
        if (k == K_JAL) begin
          c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
        end
        push_r("jump", 1'($urandom), c);
      end
      K_JR: begin
        c = '0; c.pc_write = 1'b1; c.pc_source = 2'b11; c.instr_done = 1'b1;
        push_r("jr", 1'($urandom), c);
      end
      default: begin
        c = '0; c.illegal_op = 1'b1; c.instr_done = 1'b1;
        push_r("trap", 1'($urandom), c);
      end
    endcase
  endtask

  // Apply queued steps one per cycle, checking on the falling edge
  task automatic play(input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      bus.mem_ready = s.mr;
      bus.op_code   = s.op;
      bus.funct     = s.fn;
      @(negedge clk);
      check(s.tag, sample(), s.c);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    logic [5:0] ops [10];
    logic [5:0] op, fn;
    ctl_t       c;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001100,
            6'b000100, 6'b000010, 6'b000011, 6'b111111, 6'b010001};
    bus.mem_ready = 1'b1;
    bus.op_code   = 6'd0;
    bus.funct     = 6'd0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", sample(), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    add_instr(6'b000000, 6'b100000, 0, 0);
    add_instr(6'b100011, 6'b010101, 0, 2);
    add_instr(6'b000100, 6'b000000, 0, 0);
    add_instr(6'b111111, 6'b000000, 0, 0);
    add_instr(6'b000011, 6'b000000, 0, 0);
    add_instr(6'b000000, 6'b001000, 0, 0);
    add_instr(6'b101011, 6'b000000, 2, 1);
    add_instr(6'b001000, 6'b000000, 1, 0);
    add_instr(6'b001100, 6'b000000, 0, 0);
    add_instr(6'b000010, 6'b000000, 0, 0);
    play(100000);

    repeat (60) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
      add_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    play(100000);

    add_instr(6'b101011, 6'b000000, 0, 3);
    play(4);
    bus.mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("reset_mid_mem_wr", sample(), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
    check("fetch_after_reset", sample(), c);
    q.delete();
    add_instr(6'b000000, 6'b100010, 1, 0);
    add_instr(6'b100011, 6'b000000, 0, 1);
    play(100000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle MIPS control unit. It replaces the single-cycle opcode decoder with a registered state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It stalls on a memory ready handshake and flags illegal opcodes. It sits between the instruction register (op_code/funct fields) and the shared-memory multicycle datapath (PC, IR, MDR, A/B, ALUOut registers).

## Interface
Parameters:
- OP_W, 6, opcode field width
- FUNCT_W, 6, funct field width
- ALUOP_W, 2, alu_op width; minimum 2, upper bits driven 0

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op_code  in  OP_W  IR[31:26]
- funct  in  FUNCT_W  IR[5:0]
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read / mem_write  out  1  memory strobes
- ir_write  out  1  load IR
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- reg_write  out  1  register-file write
- alu_src_a  out  1  0 PC, 1 A
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- alu_op  out  ALUOP_W  00 add, 01 sub, 10 funct-decoded, 11 and
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 A (jr)
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- instr_done  out  1  one-cycle pulse in the last cycle of every instruction

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP, JAL, JR, TRAP.
- Outputs are Moore, decoded from the state register. The only exception is that pc_write, ir_write and the wait-state exits are qualified by mem_ready.
- FETCH:
  - Asserts mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - When mem_ready=1, also asserts ir_write and pc_write, then goes to DECODE.
  - Otherwise it holds with no enables except mem_read.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000: if funct=001000, go to JR; otherwise EXEC_R.
  - 100011 or 101011: MEM_ADDR.
  - 001000 or 001100: EXEC_I.
  - 000100: BRANCH.
  - 000010: JUMP.
  - 000011: JAL.
  - Any other opcode: TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read, iord=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write, reg_dst=00, mem_to_reg=01, instr_done.
- MEM_WR: mem_write, iord=1. Holds until mem_ready; instr_done is asserted in the mem_ready cycle.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 for addi, 11 for andi.
- ALU_WB: reg_write, mem_to_reg=00, reg_dst=01 (R-type) or 00 (I-type), instr_done.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_source=01, instr_done.
- JUMP: pc_write, pc_source=10, instr_done.
- JAL: pc_write, pc_source=10, reg_write, reg_dst=10, mem_to_reg=10, instr_done. PC already holds PC+4.
- JR: pc_write, pc_source=11, instr_done.
- TRAP: illegal_op, instr_done, no writes. The instruction is skipped; PC already advanced.
- Every final state returns to FETCH.
- All unlisted outputs are 0 in each state.

## Timing
- Reset:
  - While rst_n=0: state forced to FETCH asynchronously.
  - Every enable (pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write), illegal_op and instr_done is held 0.
  - All select outputs are 0.
- First fetch starts on the first rising edge after deassertion.
- Latency with mem_ready tied 1:
  - beq, j, jal, jr, illegal: 3 cycles
  - R-type, addi, andi, sw: 4 cycles
  - lw: 5 cycles
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle, with strobes held steady.
- mem_ready outside those three states is ignored.
- op_code and funct are sampled only in DECODE; they must come from the IR loaded in FETCH.
- Reset mid-instruction aborts with no further writes. The next fetch uses whatever PC the datapath holds.

## Configuration
- MIPS_MC_JAL_JR_EN defined: JAL and JR states exist as above.
- MIPS_MC_JAL_JR_EN undefined:
  - Opcode 000011 goes to TRAP.
  - funct 001000 is treated as an ordinary R-type (EXEC_R → ALU_WB).
  - reg_dst=10, mem_to_reg=10 and pc_source=11 are never driven.

## Structure
- Package mips_mc_pkg holds:
  - state enum
  - opcode/funct localparams
  - alu_op, alu_src_b, pc_source, reg_dst and mem_to_reg codes
- Sub-module mips_mc_op_decoder is combinational. It maps op_code/funct to an instruction class enum, which DECODE and the I-type/writeback states consume.

## Test plan
- Reset then add (op 000000, funct 100000) with mem_ready=1 → states FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1, reg_dst=01 on cycle 4; instr_done on cycle 4 only.
- lw with mem_ready low 2 cycles in MEM_RD → 7 cycles total; mem_read and iord=1 steady; reg_write and mem_to_reg=01 only in the final cycle.
- beq → pc_write_cond=1, alu_op=01, pc_source=01 in cycle 3; no reg_write anywhere.
- Opcode 111111 → illegal_op pulse in cycle 3, no writes, FETCH in cycle 4.
- jal with macro → cycle 3 reg_dst=10, mem_to_reg=10, pc_write=1. Without macro → illegal_op.
- Async rst_n low mid MEM_WR → mem_write drops immediately; FETCH after release; no pc_write until mem_ready.
